print_tx: RTL and testbench

- Transmit-side formatter for the serial debug unit; the counterpart of the receive-side scanner.
- Accepts a print request from the debug controller (or one of its command sub-units) as a 32-bit value plus a type flag.
- Serialises the request into a stream of ASCII characters.
- Hands each character to the UART transmitter over a valid/ready handshake, then reports completion with a one-cycle acknowledge.

---
 rtl/print_tx.sv | 89 ++++++++
 tb/tb_print_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/print_tx.sv
// rtl/print_tx.sv - transmit-side formatter: one character or 8 hex digits to the UART
// Serialises a captured request over a valid/ready stream and acknowledges completion once.
module print_tx #(
  parameter bit         HEX_UPPER = 1'b1,
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx,
  input  logic        type_tx,
  input  logic        req_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, DONE, HOLD} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [27:0] data;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  // The top nibble is encoded straight from dout_tx at acceptance, so only
  // the remaining 28 bits are kept and shifted up one nibble per transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      d_tx   <= 8'h00;
      vld_tx <= 1'b0;
      ack_tx <= 1'b0;
      busy   <= 1'b0;
      cnt    <= 4'd0;
      data   <= 28'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_tx) begin
            data   <= dout_tx[27:0];
            cnt    <= type_tx ? (TERM_EN ? 4'd8 : 4'd7) : 4'd0;
            d_tx   <= type_tx ? hex_char(dout_tx[31:28]) : dout_tx[7:0];
            vld_tx <= 1'b1;
            busy   <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          if (rdy_tx) begin
            if (cnt == 4'd0) begin
              vld_tx <= 1'b0;
              ack_tx <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt - 4'd1;
              if (TERM_EN && cnt == 4'd1) begin
                d_tx <= TERM_CHAR;
              end else begin
                d_tx <= hex_char(data[27:24]);
                data <= {data[23:0], 4'h0};
              end
            end
          end
        end
        DONE: begin
          ack_tx <= 1'b0;
          state  <= HOLD;
        end
        HOLD: begin
          // A level request must drop before another one is taken.
          if (!req_tx) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_print_tx.sv
// tb/tb_print_tx.sv - directed self-checking bench for print_tx
// Three instances share stimulus: defaults, lower-case hex, and no terminator.
module tb_print_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        typ;
  logic        req;
  logic [31:0] dout;

  logic [7:0] d0, d1, d2;
  logic       vld0, vld1, vld2;
  logic       ack0, ack1, ack2;
  logic       busy0, busy1, busy2;

  always #5 clk = ~clk;

  print_tx u0 (
    .clk(clk), .rst(rst), .d_tx(d0), .vld_tx(vld0), .rdy_tx(rdy), .type_tx(typ),
    .req_tx(req), .dout_tx(dout), .ack_tx(ack0), .busy(busy0)
  );
  print_tx #(.HEX_UPPER(1'b0)) u1 (
    .clk(clk), .rst(rst), .d_tx(d1), .vld_tx(vld1), .rdy_tx(rdy), .type_tx(typ),
    .req_tx(req), .dout_tx(dout), .ack_tx(ack1), .busy(busy1)
  );
  print_tx #(.TERM_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .d_tx(d2), .vld_tx(vld2), .rdy_tx(rdy), .type_tx(typ),
    .req_tx(req), .dout_tx(dout), .ack_tx(ack2), .busy(busy2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int a0 = 0, a1 = 0, a2 = 0;
  logic       stall0 = 1'b0;
  logic [7:0] prev_d0 = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Transfers are sampled mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (vld0 && rdy) q0.push_back(d0);
    if (vld1 && rdy) q1.push_back(d1);
    if (vld2 && rdy) q2.push_back(d2);
    if (ack0) a0++;
    if (ack1) a1++;
    if (ack2) a2++;
    if (!rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        check("stall_vld", {31'd0, vld0}, 32'd1);
        check("stall_d", {24'd0, d0}, {24'd0, prev_d0});
      end
      stall0  = vld0 && !rdy;
      prev_d0 = d0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); q2.delete();
    a0 = 0; a1 = 0; a2 = 0;
  endtask

  task automatic check_seq(input string tag, input int which, input logic [71:0] exp, input int n);
    int sz;
    logic [7:0] g;
    sz = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
    check({tag, "_len"}, sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      g = (which == 0) ? q0[i] : (which == 1) ? q1[i] : q2[i];
      check(tag, {24'd0, g}, {24'd0, exp[8*(n-1-i) +: 8]});
    end
  endtask

  // Latency is the cycle index, relative to acceptance edge N, in which ack is first high.
  task automatic run_req(input logic [31:0] d, input logic t, input bit hold,
                         output int l0, output int l1, output int l2);
    dout = d; typ = t; req = 1'b1;
    l0 = -1; l1 = -1; l2 = -1;
    @(posedge clk);
    #1;
    check("busy_on", {31'd0, busy0}, 32'd1);
    check("vld_on", {31'd0, vld0}, 32'd1);
    if (!hold) req = 1'b0;
    for (int j = 1; j <= 400 && (l0 < 0 || l1 < 0 || l2 < 0); j++) begin
      @(posedge clk);
      #1;
      if (l0 < 0 && ack0) l0 = j + 1;
      if (l1 < 0 && ack1) l1 = j + 1;
      if (l2 < 0 && ack2) l2 = j + 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l0, l1, l2;
    bit done3;
    rst = 1'b0; req = 1'b0; typ = 1'b0; dout = 32'd0; rdy = 1'b1;
    tick(3);
    check("rst_vld", {31'd0, vld0}, 32'd0);
    check("rst_ack", {31'd0, ack0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_d", {24'd0, d0}, 32'd0);
    rst = 1'b1;
    tick(2);
    check("idle_vld", {31'd0, vld0}, 32'd0);

    // single character
    clear_all();
    run_req(32'h0000_0041, 1'b0, 1'b0, l0, l1, l2);
    tick(3);
    check("t0_lat", l0, 2);
    check_seq("t0_seq", 0, 72'h41, 1);
    check("t0_ack_cnt", a0, 1);
    check("t0_busy_off", {31'd0, busy0}, 32'd0);

    // hex word at full throughput
    clear_all();
    run_req(32'h1234_ABCD, 1'b1, 1'b0, l0, l1, l2);
    tick(3);
    check("hex_lat", l0, 10);
    check_seq("hex_seq", 0, "1234ABCD ", 9);
    check_seq("hex_lower", 1, "1234abcd ", 9);
    check("hex_ack_cnt", a0, 1);

    // backpressure with mid-send input changes
    clear_all();
    done3 = 1'b0;
    fork
      begin
        run_req(32'h1234_ABCD, 1'b1, 1'b0, l0, l1, l2);
        done3 = 1'b1;
      end
      begin
        for (int k = 0; !done3; k++) begin
          @(posedge clk);
          #1;
          if (!done3)
            rdy = (k % 3 == 1) ? 1'b0 : (k % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        rdy = 1'b1;
      end
      begin
        tick(4);
        dout = 32'hFFFF_FFFF;
        typ  = 1'b0;
      end
    join
    tick(3);
    check("bp_slower", {31'd0, l0 > 10}, 32'd1);
    check_seq("bp_seq", 0, "1234ABCD ", 9);
    check("bp_ack_cnt", a0, 1);

    // request held high after ack
    clear_all();
    run_req(32'h0000_00FF, 1'b1, 1'b1, l0, l1, l2);
    tick(50);
    check("hold_ack_cnt", a0, 1);
    check_seq("hold_seq", 0, "000000FF ", 9);
    check("hold_busy", {31'd0, busy0}, 32'd1);
    req = 1'b0;
    tick(1);
    clear_all();
    run_req(32'hDEAD_BEEF, 1'b1, 1'b0, l0, l1, l2);
    tick(3);
    check_seq("beef_lower", 1, "deadbeef ", 9);
    check_seq("beef_upper", 0, "DEADBEEF ", 9);

    // reset in the middle of a word
    clear_all();
    dout = 32'hFFFF_0000; typ = 1'b1; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, vld0}, 32'd0);
    check("mid_rst_ack", {31'd0, ack0}, 32'd0);
    check("mid_rst_busy", {31'd0, busy0}, 32'd0);
    check_seq("mid_rst_seq", 0, "FFF", 3);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("mid_rst_no_ack", a0, 0);
    clear_all();
    run_req(32'h0000_005A, 1'b0, 1'b0, l0, l1, l2);
    tick(3);
    check("post_rst_lat", l0, 2);
    check_seq("post_rst_seq", 0, 72'h5A, 1);

    // no terminator
    clear_all();
    run_req(32'h0000_0009, 1'b1, 1'b0, l0, l1, l2);
    tick(3);
    check("noterm_lat", l2, 9);
    check_seq("noterm_seq", 2, "00000009", 8);
    check("noterm_ack_cnt", a2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
